// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//
// Pipeline register between the ALU and the memory stage. ALU results and
// destination metadata are taken under a valid/ready handshake into a
// two-entry buffer (main = head, skid = overflow slot). The skid slot exists
// because in_ready is registered: a stall seen on out_ready only reaches
// in_ready one cycle later, and the result that arrives during that cycle
// needs somewhere to go.
//
// Optional feature macro: OVF_TRAP_EN
//   defined   - a trapping ADD/SUB that overflowed sets trap_pending. The
//               stage then stops accepting until flush, while already
//               buffered entries still drain.
//   undefined - overflow is never qualified. reg_write passes through
//               unmasked and out_ovf_exc stays 0.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   ALU-side handshake (in_ready is registered)
//   alu_result/zero  ALU outputs, stored bit-exact
//   alu_ovf, chk_ovf overflow flag and "overflow is meaningful" qualifier
//   rd_addr          destination register
//   reg_write        instruction writes rd
//   flush            synchronous kill of all buffered entries
//   out_*            head entry towards the memory stage
//   fwd_valid        head entry is a usable forwarding source

module ex_mem_stage #(
    parameter int n  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [n-1:0]  alu_result,
    input  logic          alu_zero,
    input  logic          alu_ovf,
    input  logic          chk_ovf,
    input  logic [RA-1:0] rd_addr,
    input  logic          reg_write,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [n-1:0]  out_result,
    output logic          out_zero,
    output logic [RA-1:0] out_rd_addr,
    output logic          out_reg_write,
    output logic          out_ovf_exc,
    output logic          fwd_valid
);

    // state | meaning
    // EMPTY | no entry buffered
    // ONE   | main (head) valid
    // TWO   | main and skid valid, in_ready is 0
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          in_ready_q;
    logic          in_ready_d;
    logic          trap_d;
    logic          trap_q;

    logic          accept;
    logic          pop;
    logic          exc_in;
    logic          rw_in;

    logic          ld_main_in;
    logic          ld_main_skid;
    logic          ld_skid;

    logic [n-1:0]  main_result, skid_result;
    logic          main_zero,   skid_zero;
    logic [RA-1:0] main_rd,     skid_rd;
    logic          main_rw,     skid_rw;
    logic          main_exc,    skid_exc;

`ifdef OVF_TRAP_EN
    assign exc_in = alu_ovf & chk_ovf;
`else
    logic unused_ovf;
    assign unused_ovf = alu_ovf ^ chk_ovf;
    assign exc_in     = 1'b0;
`endif

    // A trapping entry must never write its destination.
    assign rw_in  = reg_write & ~exc_in;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            // Flush wins over everything, including a same-cycle accept.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        ld_main_in = 1'b1;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        ld_skid = 1'b1;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is 0 here, so no accept can coincide.
                    if (pop) begin
                        ld_main_skid = 1'b1;
                        state_d      = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`ifdef OVF_TRAP_EN
    always_comb begin
        trap_d = trap_q;
        if (flush) begin
            trap_d = 1'b0;
        end else if (accept && exc_in) begin
            trap_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
`else
    assign trap_d = 1'b0;
    assign trap_q = 1'b0;
`endif

    assign in_ready_d = (state_d != TWO) && !trap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_result <= '0;
            main_zero   <= 1'b0;
            main_rd     <= '0;
            main_rw     <= 1'b0;
            main_exc    <= 1'b0;
        end else if (ld_main_in) begin
            main_result <= alu_result;
            main_zero   <= alu_zero;
            main_rd     <= rd_addr;
            main_rw     <= rw_in;
            main_exc    <= exc_in;
        end else if (ld_main_skid) begin
            main_result <= skid_result;
            main_zero   <= skid_zero;
            main_rd     <= skid_rd;
            main_rw     <= skid_rw;
            main_exc    <= skid_exc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_result <= '0;
            skid_zero   <= 1'b0;
            skid_rd     <= '0;
            skid_rw     <= 1'b0;
            skid_exc    <= 1'b0;
        end else if (ld_skid) begin
            skid_result <= alu_result;
            skid_zero   <= alu_zero;
            skid_rd     <= rd_addr;
            skid_rw     <= rw_in;
            skid_exc    <= exc_in;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != EMPTY);
    assign out_result    = main_result;
    assign out_zero      = main_zero;
    assign out_rd_addr   = main_rd;
    assign out_reg_write = main_rw;
    assign out_ovf_exc   = main_exc;
    // Register 0 is hard-wired, so it is never a forwarding source.
    assign fwd_valid     = out_valid & main_rw & (main_rd != '0);

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_ovf;
    logic        chk_ovf;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;
    logic        out_ovf_exc;
    logic        fwd_valid;

    always #5 clk = ~clk;

    ex_mem_stage #(.n(32), .RA(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_ovf      (alu_ovf),
        .chk_ovf      (chk_ovf),
        .rd_addr      (rd_addr),
        .reg_write    (reg_write),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_rd_addr  (out_rd_addr),
        .out_reg_write(out_reg_write),
        .out_ovf_exc  (out_ovf_exc),
        .fwd_valid    (fwd_valid)
    );

    // Reference model: an in-order queue of accepted entries, capacity 2.
    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic [4:0]  rd;
        logic        rw;
        logic        exc;
    } ent_t;

    ent_t q[$];
    bit   m_in_ready;
    bit   m_trap;
    bit   m_last_acc;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] r, input bit z, input bit ov,
                         input bit ck, input logic [4:0] rd, input bit rw,
                         input bit fl, input bit ordy);
        in_valid   = v;
        alu_result = r;
        alu_zero   = z;
        alu_ovf    = ov;
        chk_ovf    = ck;
        rd_addr    = rd;
        reg_write  = rw;
        flush      = fl;
        out_ready  = ordy;
    endtask

    task automatic check_outputs();
        ent_t h;
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_in_ready});
        if (q.size() != 0) begin
            h = q[0];
            chk("out_result", {32'd0, out_result}, {32'd0, h.res});
            chk("out_zero", {63'd0, out_zero}, {63'd0, h.z});
            chk("out_rd_addr", {59'd0, out_rd_addr}, {59'd0, h.rd});
            chk("out_reg_write", {63'd0, out_reg_write}, {63'd0, h.rw});
            chk("out_ovf_exc", {63'd0, out_ovf_exc}, {63'd0, h.exc});
            chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, h.rw && (h.rd != 5'd0)});
        end else begin
            chk("fwd_valid_empty", {63'd0, fwd_valid}, 64'd0);
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit   acc;
        bit   pp;
        ent_t e;
        @(negedge clk);
        check_outputs();
        acc   = in_valid && m_in_ready;
        pp    = (q.size() != 0) && out_ready;
        e.res = alu_result;
        e.z   = alu_zero;
        e.rd  = rd_addr;
`ifdef OVF_TRAP_EN
        e.exc = alu_ovf && chk_ovf;
`else
        e.exc = 1'b0;
`endif
        e.rw  = reg_write && !e.exc;
        @(posedge clk);
        m_last_acc = 1'b0;
        if (flush) begin
            q.delete();
            m_trap = 1'b0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                m_last_acc = 1'b1;
                if (e.exc) m_trap = 1'b1;
            end
        end
        m_in_ready = (q.size() < 2) && !m_trap;
        #1;
    endtask

    initial begin
        int n_acc;
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 1);
        rst_n      = 1'b0;
        m_in_ready = 1'b1;
        m_trap     = 1'b0;
        m_last_acc = 1'b0;

        // Reset values
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_result", {32'd0, out_result}, 64'd0);
        chk("rst_out_rd", {59'd0, out_rd_addr}, 64'd0);
        chk("rst_out_rw", {63'd0, out_reg_write}, 64'd0);
        chk("rst_out_exc", {63'd0, out_ovf_exc}, 64'd0);
        chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stream 10, 20, 30 with out_ready held high
        drive(1, 32'd10, 0, 0, 0, 5'd1, 1, 0, 1); step();
        drive(1, 32'd20, 0, 0, 0, 5'd2, 1, 0, 1); step();
        drive(1, 32'd30, 1, 0, 0, 5'd3, 1, 0, 1); step();
        drive(0, 32'd0,  0, 0, 0, 5'd0, 0, 0, 1); step();
        step();

        // Backpressure: offer 5, 6, 7 with out_ready low
        drive(1, 32'd5, 0, 0, 0, 5'd4, 1, 0, 0); step();
        drive(1, 32'd6, 0, 0, 0, 5'd5, 1, 0, 0); step();
        drive(1, 32'd7, 0, 0, 0, 5'd6, 1, 0, 0); step();
        chk("skid_in_ready_low", {63'd0, in_ready}, 64'd0);
        step();
        out_ready = 1'b1;
        n_acc = 0;
        while (!m_last_acc && n_acc < 10) begin
            step();
            n_acc++;
        end
        if (!m_last_acc) chk("wait_accept_7", 64'd0, 64'd1);
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 1);
        step(); step(); step();

        // Forwarding: rd 0 suppressed, rd 3 forwarded
        drive(1, 32'h1234, 0, 0, 0, 5'd0, 1, 0, 0); step();
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 1); step();
        drive(1, 32'h5678, 0, 0, 0, 5'd3, 1, 0, 0); step();
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 1); step();
        step();

        // Overflow not checked (ADDU): writes rd, no stall
        drive(1, 32'h8000_0000, 0, 1, 0, 5'd8, 1, 0, 1); step();
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 1); step();
        chk("addu_in_ready", {63'd0, in_ready}, 64'd1);
        step();

        // Overflow checked: masked write; with traps enabled, stall until flush
        drive(1, 32'h8000_0000, 0, 1, 1, 5'd8, 1, 0, 1); step();
        drive(1, 32'h1, 0, 0, 0, 5'd9, 1, 0, 1); step(); step(); step();
`ifdef OVF_TRAP_EN
        chk("trap_in_ready", {63'd0, in_ready}, 64'd0);
`endif
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 1, 1); step();
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 1); step();
        chk("post_flush_in_ready", {63'd0, in_ready}, 64'd1);

        // Flush in ONE with simultaneous accept: nothing survives
        drive(1, 32'hAA, 0, 0, 0, 5'd7, 1, 0, 0); step();
        drive(1, 32'hBB, 0, 0, 0, 5'd7, 1, 1, 0); step();
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 1); step();
        step();

        // Reset mid-transfer discards everything immediately
        drive(1, 32'hC1, 0, 0, 0, 5'd1, 1, 0, 0); step();
        drive(1, 32'hC2, 0, 0, 0, 5'd2, 1, 0, 0); step();
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_rst_fwd", {63'd0, fwd_valid}, 64'd0);
        #1 rst_n = 1'b1;
        q.delete();
        m_trap     = 1'b0;
        m_in_ready = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Randomised traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1),
                  5'($urandom_range(0, 31)), $urandom_range(0, 1),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
            step();
        end
        drive(0, 32'd0, 0, 0, 0, 5'd0, 0, 0, 1);
        step(); step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register between the ALU and the memory stage. It captures the ALU's combinational outputs together with destination-register metadata under a valid/ready handshake, and buffers up to two results in a skid arrangement so that a memory-side stall never drops an in-flight ALU result. The head entry is also exposed to the operand-forwarding logic. Signed-overflow exceptions are qualified here.

## Interface
- n, 32, data width; must match the ALU's n.
- RA, 5, register-address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept; registered.
- alu_result  in  n  ALU Result.
- alu_zero  in  1  ALU Zero.
- alu_ovf  in  1  ALU Overflow.
- chk_ovf  in  1  instruction is a trapping ADD/SUB, so overflow is meaningful.
- rd_addr  in  RA  destination register.
- reg_write  in  1  instruction writes rd.
- flush  in  1  synchronous kill of all buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts head.
- out_result  out  n  head result.
- out_zero  out  1  head Zero.
- out_rd_addr  out  RA  head destination.
- out_reg_write  out  1  head write enable, after exception masking.
- out_ovf_exc  out  1  head raised overflow exception.
- fwd_valid  out  1  out_valid & out_reg_write & (out_rd_addr != 0).

## Operation
- Storage is two entries: main (head) and skid. Each entry holds result, zero, rd_addr, reg_write and exc. exc is alu_ovf & chk_ovf.
- Handshake terms: accept = in_valid & in_ready; pop = out_valid & out_ready.
- State encoding: EMPTY, ONE (main valid), TWO (main and skid valid).
- Transitions from EMPTY:
  - accept → ONE, main loads.
  - otherwise stay in EMPTY.
- Transitions from ONE:
  - accept & pop → ONE, main loads new.
  - accept & ~pop → TWO, skid loads.
  - pop & ~accept → EMPTY.
  - otherwise hold.
- Transitions from TWO:
  - pop → ONE, main ← skid.
  - otherwise hold. accept cannot occur because in_ready is 0.
- in_ready is registered next-state: 1 iff next state ≠ TWO and trap_pending is 0.
- flush has highest priority. Next state is EMPTY, any simultaneous accept is discarded, and trap_pending is cleared.
- Exception masking: an entry with exc = 1 stores reg_write = 0, so the destination is never written. alu_result is still stored for debug.
- rd_addr = 0 is stored unchanged. fwd_valid suppresses forwarding for it.
- No arithmetic is performed. All fields pass through bit-exact, with no width extension.

## Timing
- Latency: accept in cycle t gives out_valid in cycle t+1 when the stage was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput is one result per cycle while out_ready stays 1.
- With out_ready held 0, at most 2 results are accepted. in_ready falls in the cycle after the second accept.
- Outputs are driven from registers only, with no combinational path from in_* to out_*.
- The out_ready → in_ready path is registered. This is why the skid entry exists.
- Reset values (asynchronous, rst_n = 0): state EMPTY, out_valid 0, in_ready 1, all data outputs 0, fwd_valid 0, trap_pending 0.
- Reset asserted mid-transfer discards all entries immediately. No partial entry survives.

## Configuration
- OVF_TRAP_EN defined:
  - Accepting an entry with exc = 1 sets trap_pending.
  - in_ready drops the next cycle and stays 0 until flush.
  - Entries already buffered still drain.
  - out_ovf_exc is that entry's exc.
- OVF_TRAP_EN undefined:
  - exc is forced 0, reg_write passes unmasked, and out_ovf_exc is tied 0.
  - trap_pending does not exist, so in_ready depends only on occupancy.

## Test plan
- Reset then stream: release rst_n, present results 10, 20, 30 on consecutive cycles with out_ready = 1 → out_result 10, 20, 30 on cycles t+1..t+3; in_ready stays 1.
- Backpressure/skid: out_ready = 0, offer 5, 6, 7 → only 5 and 6 are accepted and in_ready = 0 after the second. Raise out_ready → 5 then 6 emerge, then 7 is accepted; none lost or duplicated.
- Overflow, OVF_TRAP_EN set: alu_ovf = 1, chk_ovf = 1, reg_write = 1, rd = 8, result 0x80000000 → out_reg_write = 0, out_ovf_exc = 1, in_ready stays 0 until a flush pulse, then returns to 1.
- Overflow not checked: alu_ovf = 1, chk_ovf = 0 (ADDU) → out_reg_write = 1, out_ovf_exc = 0, no stall.
- Flush with simultaneous accept in state TWO-1 (ONE): flush = 1, in_valid = 1 → next cycle out_valid = 0 and the input is not buffered.
- Forwarding: rd = 0 with reg_write = 1 → fwd_valid = 0; rd = 3 → fwd_valid = 1 while the entry is head.
